// File: rtl/branch_update_sched_pkg.sv
// ---------------------------------------------------------------------------
// branch_update_sched_pkg
// Shared ISA header for the branch update scheduler slice.
//   ISA_XLEN      : default datapath / PC width
//   PC_INCR       : sequential-instruction PC step (fall-through address)
//   sched_state_e : scheduler FSM state encodings
//   sat_inc32     : saturating +1 helper for the 32-bit performance counters
// ---------------------------------------------------------------------------
package branch_update_sched_pkg;

  localparam int          ISA_XLEN = 32;
  localparam int unsigned PC_INCR  = 32'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } sched_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_update_sched_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding pending predictor updates. The read data is the
// registered head entry; there is no write-to-read bypass, so an entry
// pushed at edge N is visible on pop_data in the cycle after edge N.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_data   : write request and data (ignored while full)
//   pop               : consume head entry (ignored while empty)
//   pop_data          : head entry
//   full, empty       : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo
  import branch_update_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/branch_update_sched.sv
// ---------------------------------------------------------------------------
// branch_update_sched
// Collects resolved branches from execute, queues predictor updates and
// drains them one per cycle, and on a mispredict issues a one-cycle fetch
// redirect followed by a FLUSH_CYCLES-long flush of IF/ID.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   ex_valid / ex_ready              : execute-stage record handshake
//   ex_pc, ex_is_branch, ex_taken,
//   ex_predicted, ex_target          : resolved instruction record
//   hold                             : freezes queue drain only
//   upd_enable, upd_is_branch,
//   upd_pc, upd_taken                : to branch_predictor update_enable /
//                                      is_branch / pc_update / branch_taken
//   redirect_valid, redirect_pc      : one-cycle fetch redirect
//   flush                            : kill younger instructions in IF/ID
//   branch_count, mispredict_count   : saturating performance counters
// ---------------------------------------------------------------------------
module branch_update_sched
  import branch_update_sched_pkg::*;
#(
  parameter int XLEN         = ISA_XLEN,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic            ex_predicted,
  input  logic [XLEN-1:0] ex_target,
  input  logic            hold,
  output logic            upd_enable,
  output logic            upd_is_branch,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int EW  = XLEN + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  sched_state_e   state_r;
  sched_state_e   state_nxt_s;
  logic [FCW-1:0] flush_cnt_r;
  logic [FCW-1:0] flush_cnt_nxt_s;

  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [EW-1:0]  fifo_dout_s;
  logic           accept_s;
  logic           branch_acc_s;
  logic           mispredict_s;
  logic           redirect_valid_r;
  logic [XLEN-1:0] redirect_pc_r;
  logic [31:0]    branch_count_r;
  logic [31:0]    mispredict_count_r;

  assign ex_ready     = (state_r == ST_IDLE) && !fifo_full_s;
  assign accept_s     = ex_valid && ex_ready;
  assign branch_acc_s = accept_s && ex_is_branch;
  assign mispredict_s = branch_acc_s && (ex_taken != ex_predicted);

  assign upd_enable    = !fifo_empty_s && !hold;
  assign upd_is_branch = upd_enable;
  assign upd_pc        = fifo_dout_s[EW-1:1];
  assign upd_taken     = fifo_dout_s[0];

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_sync_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (branch_acc_s),
    .push_data ({ex_pc, ex_taken}),
    .pop       (upd_enable),
    .pop_data  (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // FSM state and flush-length counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= {FCW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
    end
  end

  // Next-state: a mispredict enters FLUSH, which lasts FLUSH_CYCLES cycles.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (mispredict_s) begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = {FCW{1'b0}};
        end else begin
          state_nxt_s     = ST_IDLE;
          flush_cnt_nxt_s = {FCW{1'b0}};
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FCW'(FLUSH_CYCLES - 1)) begin
          state_nxt_s     = ST_IDLE;
          flush_cnt_nxt_s = {FCW{1'b0}};
        end else begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = flush_cnt_r + FCW'(1);
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        flush_cnt_nxt_s = {FCW{1'b0}};
      end
    endcase
  end

  // flush decodes the registered state, so it rises together with redirect_valid.
  assign flush = (state_r == ST_FLUSH);

  // Redirect pulse and address; the address holds its last value between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {XLEN{1'b0}};
    end else begin
      redirect_valid_r <= mispredict_s;
      if (mispredict_s) begin
        redirect_pc_r <= ex_taken ? ex_target : (ex_pc + XLEN'(PC_INCR));
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else begin
      if (branch_acc_s) begin
        branch_count_r <= sat_inc32(branch_count_r);
      end
      if (mispredict_s) begin
        mispredict_count_r <= sat_inc32(mispredict_count_r);
      end
    end
  end

  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_update_sched.sv
// ---------------------------------------------------------------------------
// tb_branch_update_sched
// Directed scenarios with literal expectations plus a randomized phase, all
// checked every cycle against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_branch_update_sched;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic        ex_predicted;
  logic [31:0] ex_target;
  logic        hold;
  logic        upd_enable;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [32:0] mq[$];
  logic [31:0] m_bc;
  logic [31:0] m_mc;
  int          m_flush_left;
  bit          m_redir_v;
  logic [31:0] m_redir_pc;

  branch_update_sched #(
    .XLEN         (32),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_pc            (ex_pc),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_predicted     (ex_predicted),
    .ex_target        (ex_target),
    .hold             (hold),
    .upd_enable       (upd_enable),
    .upd_is_branch    (upd_is_branch),
    .upd_taken        (upd_taken),
    .upd_pc           (upd_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rec(input logic [31:0] pc, input logic br, input logic tk,
                         input logic pr, input logic [31:0] tgt);
    ex_valid     = 1'b1;
    ex_pc        = pc;
    ex_is_branch = br;
    ex_taken     = tk;
    ex_predicted = pr;
    ex_target    = tgt;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // Compare process: check DUT against the model, then advance the model
  // by what the coming rising edge must do.
  always @(negedge clk) begin
    bit exp_ready;
    bit exp_upd;
    if (reset) begin
      mq.delete();
      m_bc = 32'd0;
      m_mc = 32'd0;
      m_flush_left = 0;
      m_redir_v = 1'b0;
      m_redir_pc = 32'd0;
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_upd_enable", {31'd0, upd_enable}, 32'd0);
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_branch_count", branch_count, 32'd0);
      chk("rst_mispredict_count", mispredict_count, 32'd0);
    end else begin
      exp_ready = (m_flush_left == 0) && (mq.size() < DEPTH);
      exp_upd   = (mq.size() != 0) && !hold;
      chk("ex_ready", {31'd0, ex_ready}, {31'd0, exp_ready});
      chk("upd_enable", {31'd0, upd_enable}, {31'd0, exp_upd});
      chk("upd_is_branch", {31'd0, upd_is_branch}, {31'd0, exp_upd});
      if (exp_upd) begin
        chk("upd_pc", upd_pc, mq[0][32:1]);
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, mq[0][0]});
      end
      chk("flush", {31'd0, flush}, {31'd0, (m_flush_left > 0)});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir_v});
      if (m_redir_v) begin
        chk("redirect_pc", redirect_pc, m_redir_pc);
      end
      chk("branch_count", branch_count, m_bc);
      chk("mispredict_count", mispredict_count, m_mc);

      if (exp_upd) begin
        void'(mq.pop_front());
      end
      if (m_flush_left > 0) begin
        m_flush_left--;
      end
      m_redir_v = 1'b0;
      if (ex_valid && exp_ready && ex_is_branch) begin
        mq.push_back({ex_pc, ex_taken});
        if (m_bc != 32'hFFFF_FFFF) m_bc++;
        if (ex_taken != ex_predicted) begin
          if (m_mc != 32'hFFFF_FFFF) m_mc++;
          m_redir_v    = 1'b1;
          m_redir_pc   = ex_taken ? ex_target : (ex_pc + 32'd4);
          m_flush_left = FC;
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rpc;
    reset = 1'b1;
    hold  = 1'b0;
    set_rec(32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    ex_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("init_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("init_upd_enable", {31'd0, upd_enable}, 32'd0);
    chk("init_redirect_pc", redirect_pc, 32'd0);

    // Correctly predicted taken branch
    next_drive();
    set_rec(32'h100, 1'b1, 1'b1, 1'b1, 32'h0);
    next_drive();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("d1_upd_enable", {31'd0, upd_enable}, 32'd1);
    chk("d1_upd_pc", upd_pc, 32'h100);
    chk("d1_upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("d1_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("d1_branch_count", branch_count, 32'd1);

    // Taken branch predicted not-taken
    next_drive();
    set_rec(32'h200, 1'b1, 1'b1, 1'b0, 32'h400);
    next_drive();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("d2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("d2_redirect_pc", redirect_pc, 32'h400);
    chk("d2_flush_c1", {31'd0, flush}, 32'd1);
    chk("d2_ready_c1", {31'd0, ex_ready}, 32'd0);
    chk("d2_mispredict_count", mispredict_count, 32'd1);
    @(negedge clk);
    chk("d2_redirect_off", {31'd0, redirect_valid}, 32'd0);
    chk("d2_flush_c2", {31'd0, flush}, 32'd1);
    chk("d2_ready_c2", {31'd0, ex_ready}, 32'd0);
    @(negedge clk);
    chk("d2_flush_end", {31'd0, flush}, 32'd0);
    chk("d2_ready_back", {31'd0, ex_ready}, 32'd1);

    // Not-taken branch predicted taken: fall-through, including wrap
    next_drive();
    set_rec(32'h300, 1'b1, 1'b0, 1'b1, 32'h800);
    next_drive();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("d3_redirect_pc", redirect_pc, 32'h304);
    repeat (3) @(negedge clk);
    next_drive();
    set_rec(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h800);
    next_drive();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("d3_redirect_wrap", redirect_pc, 32'h0);
    repeat (3) @(negedge clk);

    // Hold with back-to-back correct branches fills the queue
    next_drive();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_rec(32'h1000 + 32'(4 * i), 1'b1, 1'b1, 1'b1, 32'h0);
      next_drive();
    end
    set_rec(32'h1010, 1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("d4_ready_full", {31'd0, ex_ready}, 32'd0);
    chk("d4_upd_held", {31'd0, upd_enable}, 32'd0);
    next_drive();
    ex_valid = 1'b0;
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("d4_drain_en", {31'd0, upd_enable}, 32'd1);
      chk("d4_drain_pc", upd_pc, 32'h1000 + 32'(4 * k));
    end
    @(negedge clk);
    chk("d4_drained", {31'd0, upd_enable}, 32'd0);
    chk("d4_branch_count", branch_count, 32'd8);

    // Non-branch record is accepted and dropped
    next_drive();
    set_rec(32'h500, 1'b0, 1'b1, 1'b0, 32'h900);
    next_drive();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("d5_no_update", {31'd0, upd_enable}, 32'd0);
    chk("d5_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("d5_branch_count", branch_count, 32'd8);
    chk("d5_mispredict_count", mispredict_count, 32'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      next_drive();
      rpc = $urandom;
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      set_rec(rpc, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), $urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 3) == 0);
    end

    // Reset during FLUSH with three queued entries
    next_drive();
    ex_valid = 1'b0;
    hold = 1'b0;
    repeat (10) next_drive();
    hold = 1'b1;
    set_rec(32'h2000, 1'b1, 1'b1, 1'b1, 32'h0);
    next_drive();
    set_rec(32'h2004, 1'b1, 1'b0, 1'b0, 32'h0);
    next_drive();
    set_rec(32'h2008, 1'b1, 1'b1, 1'b0, 32'h3000);
    next_drive();
    ex_valid = 1'b0;
    chk("d6_pre_flush", {31'd0, flush}, 32'd1);
    hold = 1'b0;
    reset = 1'b1;
    #1;
    chk("d6_flush", {31'd0, flush}, 32'd0);
    chk("d6_upd_enable", {31'd0, upd_enable}, 32'd0);
    chk("d6_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("d6_branch_count", branch_count, 32'd0);
    chk("d6_mispredict_count", mispredict_count, 32'd0);
    next_drive();
    reset = 1'b0;
    @(negedge clk);
    chk("d6_ready_after", {31'd0, ex_ready}, 32'd1);
    chk("d6_empty_after", {31'd0, upd_enable}, 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
